// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: state-count helper, trellis predecessor and survivor FSM states.
// The survivor unit's optional best-metric outputs are enabled by SURVIVOR_BEST_PM_EN.
package viterbi_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } spu_state_e;

    // Bits needed to name a trellis state; a 2-state trellis still needs one bit.
    function automatic int state_bits(input int num_states);
        return (num_states <= 2) ? 1 : $clog2(num_states);
    endfunction

    // Predecessor of ns under ns = {u, s[M-1:1]}: drop the MSB, shift up, decision fills the LSB.
    function automatic int pred_state(input int ns, input int m, input logic dec);
        int mask;
        mask = (1 << m) - 1;
        if (m == 1) begin
            return int'(dec);
        end
        return ((ns << 1) & mask) | int'(dec);
    endfunction

endpackage

// File: rtl/survivor_path_unit_param_pm_argmin.sv
// Combinational min tree over NUM_STATES path metrics; returns the winning index and metric.
// Pairs are reduced level by level so ties always resolve to the lowest state index.
module pm_argmin
    import viterbi_pkg::*;
#(
    parameter int  NUM_STATES = 4,
    parameter int  PM_W       = 8,
    localparam int M          = state_bits(NUM_STATES)
) (
    input  logic [NUM_STATES*PM_W-1:0] pm,
    output logic [M-1:0]               idx,
    output logic [PM_W-1:0]            value
);

    for (genvar lv = 0; lv <= M; lv++) begin : g_lv
        localparam int WIDTH = NUM_STATES >> lv;
        logic [PM_W-1:0] val [WIDTH];
        logic [M-1:0]    id  [WIDTH];

        if (lv == 0) begin : g_leaf
            for (genvar i = 0; i < WIDTH; i++) begin : g_n
                assign val[i] = pm[i*PM_W +: PM_W];
                assign id[i]  = M'(i);
            end
        end else begin : g_node
            for (genvar i = 0; i < WIDTH; i++) begin : g_n
                logic take_hi;
                // Strict compare keeps the lower-indexed half when the metrics tie.
                assign take_hi = g_lv[lv-1].val[2*i+1] < g_lv[lv-1].val[2*i];
                assign val[i]  = take_hi ? g_lv[lv-1].val[2*i+1] : g_lv[lv-1].val[2*i];
                assign id[i]   = take_hi ? g_lv[lv-1].id[2*i+1]  : g_lv[lv-1].id[2*i];
            end
        end
    end

    assign idx   = g_lv[M].id[0];
    assign value = g_lv[M].val[0];

endmodule

// File: rtl/survivor_path_unit_param.sv
// Register-exchange survivor path unit: one decoded bit per accepted step from the best path.
// Define SURVIVOR_BEST_PM_EN to add the o_best_pm / o_best_state outputs.
module survivor_path_unit_param
    import viterbi_pkg::*;
#(
    parameter int  NUM_STATES = 4,
    parameter int  PM_W       = 8,
    parameter int  TB_DEPTH   = 16,
    localparam int M          = state_bits(NUM_STATES)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [NUM_STATES*PM_W-1:0] i_pm,
    input  logic [NUM_STATES-1:0]      i_dec,
    input  logic                       i_flush,
    output logic                       o_decision,
    output logic                       o_valid,
    output logic                       o_last,
`ifdef SURVIVOR_BEST_PM_EN
    output logic [PM_W-1:0]            o_best_pm,
    output logic [M-1:0]               o_best_state,
`endif
    output spu_state_e                 dbg_state
);

    // Handshake: a step is taken on any cycle with i_valid & o_ready; o_ready drops only
    // while a flush drains, and o_valid is a one-cycle pulse with no back-pressure.

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam int IDX_W = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TB_DEPTH);

    spu_state_e state, state_nxt;

    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                accept, emit, start_flush, flush_done;
    logic [TB_DEPTH-1:0] path     [NUM_STATES];
    logic [TB_DEPTH-1:0] path_nxt [NUM_STATES];
    logic [TB_DEPTH-1:0] lat_path;
    logic [IDX_W-1:0]    flush_idx, flush_start;
    logic [M-1:0]        best_state;
    logic [PM_W-1:0]     best_pm;

    pm_argmin #(
        .NUM_STATES (NUM_STATES),
        .PM_W       (PM_W)
    ) u_argmin (
        .pm    (i_pm),
        .idx   (best_state),
        .value (best_pm)
    );

`ifndef SURVIVOR_BEST_PM_EN
    logic unused_best_pm;
    assign unused_best_pm = ^best_pm;
`endif

    // Every state extends the survivor of the predecessor its ACS decision picked.
    for (genvar s = 0; s < NUM_STATES; s++) begin : g_path
        localparam int   P0     = pred_state(s, M, 1'b0);
        localparam int   P1     = pred_state(s, M, 1'b1);
        localparam logic NS_BIT = 1'((s >> (M - 1)) & 1);
        logic [TB_DEPTH-1:0] pick;
        assign pick        = i_dec[s] ? path[P1] : path[P0];
        assign path_nxt[s] = {pick[TB_DEPTH-2:0], NS_BIT};
    end

    assign o_ready    = (state != FLUSH);
    assign accept     = i_valid && o_ready;
    assign dbg_state  = state;
    assign flush_done = (state == FLUSH) && (flush_idx == '0);

    always_comb begin
        cnt_nxt = cnt;
        if (accept && (cnt != FULL)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // The TB_DEPTH-th step and every step after it push one bit out of the path.
    assign emit = accept && (cnt_nxt == FULL);

    // Bit TB_DEPTH-1 of a full path has already been emitted, so the tail starts one lower.
    assign flush_start = (cnt_nxt == FULL) ? IDX_W'(TB_DEPTH - 2)
                                           : IDX_W'(cnt_nxt - CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_flush = 1'b0;
        case (state)
            FILL: begin
                if (i_flush && (cnt_nxt != '0)) begin
                    start_flush = 1'b1;
                    state_nxt   = FLUSH;
                end else if (emit) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_flush) begin
                    start_flush = 1'b1;
                    state_nxt   = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_idx == '0) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt        <= '0;
            path       <= '{default: '0};
            lat_path   <= '0;
            flush_idx  <= '0;
            o_decision <= 1'b0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
`ifdef SURVIVOR_BEST_PM_EN
            o_best_pm    <= '0;
            o_best_state <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            cnt     <= flush_done ? '0 : cnt_nxt;
            if (accept) begin
                path <= path_nxt;
            end
            if (emit) begin
                o_decision <= path_nxt[best_state][TB_DEPTH-1];
                o_valid    <= 1'b1;
`ifdef SURVIVOR_BEST_PM_EN
                o_best_pm    <= best_pm;
                o_best_state <= best_state;
`endif
            end
            if (state == FLUSH) begin
                o_decision <= lat_path[flush_idx];
                o_valid    <= 1'b1;
                o_last     <= (flush_idx == '0);
                flush_idx  <= flush_idx - IDX_W'(1);
            end
            // A step accepted alongside the flush is folded in before the tail is latched.
            if (start_flush) begin
                lat_path  <= accept ? path_nxt[best_state] : path[best_state];
                flush_idx <= flush_start;
            end
        end
    end

endmodule

// File: tb/tb_survivor_path_unit_param.sv
// Bench for survivor_path_unit_param: directed trellis cases plus random steps against a bit-history model.
// Build with SURVIVOR_BEST_PM_EN defined to also cover the best-metric outputs.
module tb_survivor_path_unit_param;
    import viterbi_pkg::*;

    localparam int NS  = 4;
    localparam int PW  = 2;
    localparam int TB  = 4;
    localparam int BNS = 64;
    localparam int BPW = 8;
    localparam int BTB = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic              valid = 1'b0, flush = 1'b0;
    logic [NS*PW-1:0]  pm  = '0;
    logic [NS-1:0]     dec = '0;
    logic              ready, decision, out_valid, last;
    spu_state_e        dut_state;

    logic              b_valid = 1'b0, b_flush = 1'b0;
    logic [BNS*BPW-1:0] b_pm  = '0;
    logic [BNS-1:0]    b_dec = '0;
    logic              b_ready, b_decision, b_out_valid, b_last;
    spu_state_e        b_state;

`ifdef SURVIVOR_BEST_PM_EN
    logic [PW-1:0]  best_pm;
    logic [1:0]     best_state;
    logic [BPW-1:0] b_best_pm;
    logic [5:0]     b_best_state;
`endif

    survivor_path_unit_param #(.NUM_STATES(NS), .PM_W(PW), .TB_DEPTH(TB)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_pm(pm), .i_dec(dec),
        .i_flush(flush), .o_decision(decision), .o_valid(out_valid), .o_last(last),
`ifdef SURVIVOR_BEST_PM_EN
        .o_best_pm(best_pm), .o_best_state(best_state),
`endif
        .dbg_state(dut_state)
    );

    survivor_path_unit_param #(.NUM_STATES(BNS), .PM_W(BPW), .TB_DEPTH(BTB)) dut_big (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready), .i_pm(b_pm), .i_dec(b_dec),
        .i_flush(b_flush), .o_decision(b_decision), .o_valid(b_out_valid), .o_last(b_last),
`ifdef SURVIVOR_BEST_PM_EN
        .o_best_pm(b_best_pm), .o_best_state(b_best_state),
`endif
        .dbg_state(b_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[s] bit k = k-th most recent decoded bit on the survivor ending in state s.
    int unsigned hist [NS];
    int          fill_m;
    bit          pend_q[$];
    logic [1:0]  exp_q[$];   // {last, bit}
    int          exp_best_state;
    int          exp_best_pm;

    function automatic int best_of(input logic [NS*PW-1:0] p);
        int b;
        b = 0;
        for (int s = 1; s < NS; s++) begin
            if (p[s*PW +: PW] < p[b*PW +: PW]) b = s;
        end
        return b;
    endfunction

    function automatic logic [NS*PW-1:0] pm_best(input int s);
        logic [NS*PW-1:0] r;
        r = '1;
        r[s*PW +: PW] = '0;
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) hist[s] = 0;
        fill_m = 0;
        exp_best_state = 0;
        exp_best_pm = 0;
        pend_q.delete();
        exp_q.delete();
    endtask

    task automatic model_step(input bit v, input bit f, input logic [NS*PW-1:0] p,
                              input logic [NS-1:0] d, output bit ev);
        int unsigned nh [NS];
        int best;
        int n;
        bit b;
        ev = 1'b0;
        if (pend_q.size() != 0) begin
            b = pend_q.pop_front();
            ev = 1'b1;
            exp_q.push_back({pend_q.size() == 0, b});
            if (pend_q.size() == 0) fill_m = 0;
            return;
        end
        best = best_of(p);
        if (v) begin
            for (int ns = 0; ns < NS; ns++) begin
                int unsigned pr;
                int unsigned u;
                pr = ((ns * 2) % NS) + int'(d[ns]);
                u  = ns / (NS / 2);
                nh[ns] = ((hist[pr] << 1) | u) & ((1 << TB) - 1);
            end
            for (int s = 0; s < NS; s++) hist[s] = nh[s];
            if (fill_m < TB) fill_m++;
            if (fill_m == TB) begin
                ev = 1'b1;
                exp_q.push_back({1'b0, 1'((hist[best] >> (TB - 1)) & 1)});
                exp_best_state = best;
                exp_best_pm = int'(p[best*PW +: PW]);
            end
        end
        if (f && fill_m > 0) begin
            n = (fill_m >= TB) ? TB - 1 : fill_m;
            for (int k = n - 1; k >= 0; k--) pend_q.push_back(1'((hist[best] >> k) & 1));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit f, input logic [NS*PW-1:0] p, input logic [NS-1:0] d);
        bit ev;
        valid = v;
        flush = f;
        pm    = p;
        dec   = d;
        check("ready", 32'(ready), 32'(pend_q.size() == 0));
        @(posedge clk);
        model_step(v, f, p, d, ev);
        #1;
        check("out_valid", 32'(out_valid), 32'(ev));
        check("in_flush", 32'(dut_state == FLUSH), 32'(pend_q.size() != 0));
`ifdef SURVIVOR_BEST_PM_EN
        check("best_state", 32'(best_state), 32'(exp_best_state));
        check("best_pm", 32'(best_pm), 32'(exp_best_pm));
`endif
        valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_last", 32'(last), 32'(0));
        check("rst_decision", 32'(decision), 32'(0));
        check("rst_state", 32'(dut_state), 32'(FILL));
        rst = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [1:0] sb_e;
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 32'(out_valid), 32'(0));
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_bit", 32'(decision), 32'(sb_e[0]));
                check("sb_last", 32'(last), 32'(sb_e[1]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] t3_bits;
        t3_bits = 3'b110;   // element i is the i-th tail bit: 0, 1, 1
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // All-zero stream, then reset mid-stream: next output needs TB fresh accepts.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, {2'd3, 2'd2, 2'd1, 2'd0}, '0);
        check("t1_bit", 32'(decision), 32'(0));
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, {2'd3, 2'd2, 2'd1, 2'd0}, '0);
        do_reset();

        // Message 1,0,1,1 through S2,S1,S2,S3.
        drive(1'b1, 1'b0, pm_best(2), 4'b0000);
        drive(1'b1, 1'b0, pm_best(1), 4'b0000);
        drive(1'b1, 1'b0, pm_best(2), 4'b0100);
        drive(1'b1, 1'b0, pm_best(3), 4'b0000);
        check("t2_valid", 32'(out_valid), 32'(1));
        check("t2_bit", 32'(decision), 32'(1));

        // Flush in RUN: tail bits 0,1,1 with o_last on the third.
        drive(1'b0, 1'b1, pm_best(3), 4'b0000);
        check("t3_ready", 32'(ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, pm_best(3), 4'b0000);
            check("t3_bit", 32'(decision), 32'(t3_bits[i]));
            check("t3_last", 32'(last), 32'(i == 2));
        end
        check("t3_ready_after", 32'(ready), 32'(1));
        check("t3_state_after", 32'(dut_state), 32'(FILL));

        // Ties everywhere: lowest index wins.
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, {2'd1, 2'd1, 2'd1, 2'd1}, 4'($urandom));

        // Short frame with i_valid held through the flush; flush on an empty frame is a no-op.
        do_reset();
        drive(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 8'($urandom), 4'($urandom));
        drive(1'b0, 1'b1, 8'($urandom), 4'($urandom));
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'($urandom), 4'($urandom));
        // Flush together with the TB-th accept.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'($urandom), 4'($urandom));
        drive(1'b1, 1'b1, 8'($urandom), 4'($urandom));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'($urandom), 4'($urandom));

        // Random steps, flushes and occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            else drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                       8'($urandom), 4'($urandom));
        end
        for (int i = 0; i < TB + 2; i++) drive(1'b0, 1'b0, pm, '0);
        check("drain_exp", 32'(exp_q.size()), 32'(0));

        // Wide configuration: all-ones stream along S63.
        do_reset();
        for (int s = 0; s < BNS; s++) b_pm[s*BPW +: BPW] = (s == BNS - 1) ? 8'd0 : 8'd100;
        b_dec = '1;
        check("big_ready", 32'(b_ready), 32'(1));
        for (int i = 1; i <= BTB + 8; i++) begin
            b_valid = 1'b1;
            @(posedge clk);
            #1;
            check("big_valid", 32'(b_out_valid), 32'(i >= BTB));
            if (i >= BTB) check("big_bit", 32'(b_decision), 32'(1));
            check("big_last", 32'(b_last), 32'(0));
        end
        b_valid = 1'b0;
        check("big_state", 32'(b_state), 32'(RUN));
`ifdef SURVIVOR_BEST_PM_EN
        check("big_best_state", 32'(b_best_state), 32'(BNS - 1));
        check("big_best_pm", 32'(b_best_pm), 32'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
